// File: rtl/shreg_load_shift_seq_if.sv
// shreg_load_shift_seq_if: seed-word and serial-bit valid/ready handshakes plus frame abort
// master: upstream producer (drives data/valid/abort, sees readys); slave: the sequencer
interface shreg_load_shift_seq_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] par_i;
  logic             par_valid_i;
  logic             par_ready_o;
  logic             ser_i;
  logic             ser_valid_i;
  logic             ser_ready_o;
  logic             abort_i;
  modport master (
    output par_i, par_valid_i, ser_i, ser_valid_i, abort_i,
    input  par_ready_o, ser_ready_o
  );
  modport slave (
    input  par_i, par_valid_i, ser_i, ser_valid_i, abort_i,
    output par_ready_o, ser_ready_o
  );
endinterface

// File: rtl/shreg_load_shift_seq.sv
// shreg_load_shift_seq: loads one seed word then shifts N_SHIFT serial bits into a load/shift register
// Ports: clk_i; rst_i sync active-low; bus (slave) seed/serial handshakes and abort_i;
//        I_o4/ld_o/shift_o/bstream_o drive the register; bit_cnt_o bits taken; word_done_o frame-complete pulse
module shreg_load_shift_seq #(
  parameter int WIDTH   = 4,
  parameter int N_SHIFT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  shreg_load_shift_seq_if.slave bus,
  output logic [WIDTH-1:0]      I_o4,
  output logic                  ld_o,
  output logic                  shift_o,
  output logic                  bstream_o,
  output logic [3:0]            bit_cnt_o,
  output logic                  word_done_o
);
  localparam logic [3:0] LAST = 4'(N_SHIFT - 1);
  localparam logic [3:0] FULL = 4'(N_SHIFT);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] i_q, i_d;
  logic             ld_q, shift_q, bs_q, bs_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             par_acc, ser_acc;
  // readys are masked while reset is asserted so nothing looks accepted on a reset edge
  assign bus.par_ready_o = rst_i && state_q == IDLE;
  assign bus.ser_ready_o = rst_i && state_q == SHIFT && !bus.abort_i;
  assign par_acc = bus.par_valid_i && bus.par_ready_o;
  assign ser_acc = bus.ser_valid_i && bus.ser_ready_o;
  always_comb begin
    state_d = state_q == IDLE  ? (par_acc ? SHIFT : IDLE)
            : state_q == SHIFT ? (bus.abort_i ? IDLE : (ser_acc && cnt_q == LAST) ? DONE : SHIFT)
            : IDLE;
    i_d   = par_acc ? bus.par_i : i_q;
    bs_d  = ser_acc ? bus.ser_i : bs_q;
    cnt_d = (par_acc || (state_q == SHIFT && bus.abort_i)) ? 4'd0
          : (ser_acc && cnt_q != FULL) ? cnt_q + 4'd1 : cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      i_q     <= '0;
      ld_q    <= 1'b0;
      shift_q <= 1'b0;
      bs_q    <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      ld_q    <= par_acc;
      shift_q <= ser_acc;
      bs_q    <= bs_d;
      cnt_q   <= cnt_d;
    end
  end
  assign I_o4        = i_q;
  assign ld_o        = ld_q;
  assign shift_o     = shift_q;
  assign bstream_o   = bs_q;
  assign bit_cnt_o   = cnt_q;
  // Moore pulse: coincides with the final shift strobe
  assign word_done_o = state_q == DONE;
endmodule

// File: tb/tb_shreg_load_shift_seq.sv
// tb_shreg_load_shift_seq: directed and randomized checks against a frame-level reference model
module tb_shreg_load_shift_seq;
  localparam int WIDTH = 4;
  localparam int N     = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  shreg_load_shift_seq_if #(.WIDTH(WIDTH)) bus();
  logic [WIDTH-1:0] I;
  logic             ld, shift, bs, wd;
  logic [3:0]       cnt;
  shreg_load_shift_seq #(.WIDTH(WIDTH), .N_SHIFT(N)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .I_o4(I), .ld_o(ld), .shift_o(shift),
    .bstream_o(bs), .bit_cnt_o(cnt), .word_done_o(wd)
  );
  int errors = 0;
  int checks = 0;
  // downstream consumer register: {ld,shift}={1,1} is treated as shift
  logic [3:0] dreg;
  always @(posedge clk) begin
    if (shift) dreg <= {dreg[2:0], bs};
    else if (ld) dreg <= I;
  end
  // reference model: frame open / done-cycle flags plus expected registered outputs
  logic             m_frame = 1'b0, m_done = 1'b0;
  logic [WIDTH-1:0] e_I = '0;
  logic             e_ld = 1'b0, e_shift = 1'b0, e_bs = 1'b0;
  logic [3:0]       e_cnt = 4'd0;
  function automatic logic x_pr();
    return rst && !m_frame && !m_done;
  endfunction
  function automatic logic x_sr();
    return rst && m_frame && !bus.abort_i;
  endfunction
  function automatic logic [13:0] x_vec();
    return {x_pr(), x_sr(), e_I, e_ld, e_shift, e_bs, e_cnt, m_done};
  endfunction
  function automatic logic [13:0] obs();
    return {bus.par_ready_o, bus.ser_ready_o, I, ld, shift, bs, cnt, wd};
  endfunction
  task automatic drive(input logic r, input logic pv, input logic [WIDTH-1:0] p,
                       input logic sv, input logic s, input logic ab);
    rst = r;
    bus.par_valid_i = pv;
    bus.par_i = p;
    bus.ser_valid_i = sv;
    bus.ser_i = s;
    bus.abort_i = ab;
    @(negedge clk);
  endtask
  task automatic adv();
    logic pacc, sacc;
    if (!rst) begin
      m_frame = 1'b0; m_done = 1'b0; e_I = '0; e_ld = 1'b0; e_shift = 1'b0; e_bs = 1'b0; e_cnt = 4'd0;
    end else begin
      pacc = bus.par_valid_i && x_pr();
      sacc = bus.ser_valid_i && x_sr();
      e_ld = pacc;
      e_shift = sacc;
      if (pacc) begin
        e_I = bus.par_i; e_cnt = 4'd0; m_frame = 1'b1;
      end else if (m_done) m_done = 1'b0;
      else if (m_frame && bus.abort_i) begin
        m_frame = 1'b0; e_cnt = 4'd0;
      end else if (sacc) begin
        e_bs = bus.ser_i;
        e_cnt = e_cnt + 4'd1;
        if (e_cnt == N) begin m_frame = 1'b0; m_done = 1'b1; end
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      if (i < 2) drive(1'b0, 1'b1, WIDTH'($urandom), 1'b1, 1'($urandom), 1'b0);
      else drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs() !== x_vec()) begin
        errors++; $display("FAIL reset cyc%0d: got %b expected %b", i, obs(), x_vec());
      end
      if (i == 2) begin
        checks++;
        if (bus.par_ready_o !== 1'b1 || {I, ld, shift, bs, cnt, wd} !== 12'd0) begin
          errors++; $display("FAIL reset_release: par_ready=%b outs=%b expected 1 and zeros", bus.par_ready_o, {I, ld, shift, bs, cnt, wd});
        end
      end
      adv();
    end
  endtask
  task automatic test_full_frame();
    logic [3:0] bits = 4'b1011;
    int nld = 0, nsh = 0, wd_ok = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) drive(1'b1, 1'b1, 4'b1010, 1'b0, 1'b0, 1'b0);
      else if (i <= 4) drive(1'b1, 1'b0, '0, 1'b1, bits[4-i], 1'b0);
      else drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs() !== x_vec()) begin
        errors++; $display("FAIL full_frame cyc%0d: got %b expected %b", i, obs(), x_vec());
      end
      nld += int'(ld);
      nsh += int'(shift);
      if (wd && shift && nsh == 4) wd_ok++;
      adv();
    end
    checks++;
    if (nld != 1 || nsh != 4 || wd_ok != 1) begin
      errors++; $display("FAIL full_frame_strobes: ld=%0d shift=%0d done_with_4th=%0d expected 1 4 1", nld, nsh, wd_ok);
    end
    checks++;
    if (dreg !== 4'b1011) begin
      errors++; $display("FAIL full_frame_reg: got %b expected 1011", dreg);
    end
  endtask
  task automatic test_gapped();
    logic pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int   cseq[7] = '{1, 1, 1, 2, 3, 3, 4};
    int   nwd = 0;
    for (int i = 0; i < 11; i++) begin
      if (i == 0) drive(1'b1, 1'b1, WIDTH'($urandom), 1'b0, 1'b0, 1'b0);
      else if (i <= 7) drive(1'b1, 1'b0, '0, pat[i-1], 1'($urandom), 1'b0);
      else drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs() !== x_vec()) begin
        errors++; $display("FAIL gapped cyc%0d: got %b expected %b", i, obs(), x_vec());
      end
      if (i >= 2 && i <= 8) begin
        checks++;
        if (cnt !== 4'(cseq[i-2])) begin
          errors++; $display("FAIL gapped_cnt cyc%0d: got %0d expected %0d", i, cnt, cseq[i-2]);
        end
      end
      nwd += int'(wd);
      adv();
    end
    checks++;
    if (nwd != 1) begin
      errors++; $display("FAIL gapped_done: got %0d pulses expected 1", nwd);
    end
  endtask
  task automatic test_abort();
    for (int i = 0; i < 11; i++) begin
      if (i == 0 || i == 4) drive(1'b1, 1'b1, WIDTH'($urandom), 1'b0, 1'b0, 1'b0);
      else if (i == 3) drive(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b1);
      else if (i <= 8) drive(1'b1, 1'b0, '0, 1'b1, 1'($urandom), 1'b0);
      else drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs() !== x_vec()) begin
        errors++; $display("FAIL abort cyc%0d: got %b expected %b", i, obs(), x_vec());
      end
      if (i == 3) begin
        checks++;
        if (bus.ser_ready_o !== 1'b0) begin
          errors++; $display("FAIL abort_ready: got %b expected 0", bus.ser_ready_o);
        end
      end
      if (i == 4) begin
        checks++;
        if (shift !== 1'b0 || cnt !== 4'd0 || bus.par_ready_o !== 1'b1) begin
          errors++; $display("FAIL abort_idle: shift=%b cnt=%0d par_ready=%b expected 0 0 1", shift, cnt, bus.par_ready_o);
        end
      end
      if (i == 9) begin
        checks++;
        if (wd !== 1'b1 || cnt !== 4'd4) begin
          errors++; $display("FAIL abort_next_frame: done=%b cnt=%0d expected 1 4", wd, cnt);
        end
      end
      adv();
    end
  endtask
  task automatic test_ignored();
    logic pv[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic sv[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int   nld = 0, nsh = 0;
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, pv[i], WIDTH'($urandom), sv[i], 1'($urandom), i == 9);
      checks++;
      if (obs() !== x_vec()) begin
        errors++; $display("FAIL ignored cyc%0d: got %b expected %b", i, obs(), x_vec());
      end
      nld += int'(ld);
      nsh += int'(shift);
      adv();
    end
    checks++;
    if (nld != 2 || nsh != 4) begin
      errors++; $display("FAIL ignored_strobes: ld=%0d shift=%0d expected 2 4", nld, nsh);
    end
  endtask
  task automatic test_reset_mid();
    int nwd = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) drive(1'b1, 1'b1, WIDTH'($urandom), 1'b0, 1'b0, 1'b0);
      else if (i <= 2) drive(1'b1, 1'b0, '0, 1'b1, 1'($urandom), 1'b0);
      else if (i == 3) drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
      else drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs() !== x_vec()) begin
        errors++; $display("FAIL reset_mid cyc%0d: got %b expected %b", i, obs(), x_vec());
      end
      if (i == 4) begin
        checks++;
        if (shift !== 1'b0 || ld !== 1'b0 || cnt !== 4'd0 || bus.par_ready_o !== 1'b1) begin
          errors++; $display("FAIL reset_mid_idle: shift=%b ld=%b cnt=%0d par_ready=%b expected 0 0 0 1", shift, ld, cnt, bus.par_ready_o);
        end
      end
      nwd += int'(wd);
      adv();
    end
    checks++;
    if (nwd != 0) begin
      errors++; $display("FAIL reset_mid_done: got %0d pulses expected 0", nwd);
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 39) != 0, $urandom_range(0, 1) == 1, WIDTH'($urandom),
            $urandom_range(0, 9) < 6, 1'($urandom), $urandom_range(0, 9) == 0);
      checks++;
      if (obs() !== x_vec()) begin
        errors++; $display("FAIL random cyc%0d: got %b expected %b", i, obs(), x_vec());
      end
      checks++;
      if (ld && shift) begin
        errors++; $display("FAIL random_overlap cyc%0d: ld=%b shift=%b expected not both", i, ld, shift);
      end
      adv();
    end
  endtask
  initial begin
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    adv();
    test_reset();
    test_full_frame();
    test_gapped();
    test_abort();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/shreg_load_shift_seq.md
Name: shreg_load_shift_seq

Overview:
- Upstream sequencer for the team's 4-bit load/shift register, i.e. the register with parallel input I, controls ld/shift and serial input bstream.
- Accepts one parallel seed word over a valid/ready handshake and drives a one-cycle load strobe.
- Then accepts exactly N_SHIFT serial bits over a second valid/ready handshake and drives one shift strobe per accepted bit.
- Flags frame completion so the downstream consumer knows when the register contents are final.

Parameters:
- WIDTH, 4, width of the parallel seed word and of I_o4.
- N_SHIFT, 4, serial bits accepted per frame; legal range 1..15.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- par_i  in  WIDTH  parallel seed word.
- par_valid_i  in  1  seed word is valid.
- par_ready_o  out  1  sequencer can accept a seed word.
- ser_i  in  1  serial data bit.
- ser_valid_i  in  1  serial bit is valid.
- ser_ready_o  out  1  sequencer can accept a serial bit.
- abort_i  in  1  abandons the current frame.
- I_o4  out  WIDTH  registered seed word, to the register's parallel input.
- ld_o  out  1  registered load strobe, to the register's ld input.
- shift_o  out  1  registered shift strobe, to the register's shift input.
- bstream_o  out  1  registered serial bit, to the register's serial input.
- bit_cnt_o  out  4  bits shifted in the current frame.
- word_done_o  out  1  one-cycle pulse; frame complete.

Behaviour:
- Reset (rst_i=0 at an edge): state=IDLE; I_o4=0, ld_o=0, shift_o=0, bstream_o=0, bit_cnt_o=0, word_done_o=0.
  - Reset applies mid-frame too; strobes are low from the first cycle after that edge.
  - No partial frame resumes.
- States are IDLE, SHIFT and DONE.
  - IDLE: par_ready_o=1, ser_ready_o=0.
  - SHIFT: par_ready_o=0, ser_ready_o = !abort_i.
  - DONE: both readys 0; word_done_o=1 (Moore output).
- Transitions:
  - IDLE to SHIFT on par_valid_i=1. At that edge: I_o4<=par_i, ld_o<=1, bit_cnt_o<=0.
  - In SHIFT, each edge with ser_valid_i&&ser_ready_o: shift_o<=1, bstream_o<=ser_i, bit_cnt_o<=bit_cnt_o+1.
  - SHIFT to DONE on the edge accepting bit number N_SHIFT, i.e. bit_cnt_o==N_SHIFT-1.
  - DONE to IDLE unconditionally after one cycle.
- Strobes:
  - ld_o and shift_o are each high for exactly one cycle per accepted item, otherwise 0.
  - ld_o and shift_o are never high in the same cycle. The register treats {1,1} as shift, so overlap is a bug.
  - A cycle in SHIFT without ser_valid_i gives shift_o=0 (register holds). bstream_o and bit_cnt_o hold.
  - I_o4 holds its value until the next accepted seed word.
- Latency:
  - Seed accepted at edge N gives ld_o high in cycle N..N+1, and the register loads at edge N+1.
  - The first serial bit can be accepted at edge N+1 at the earliest. Its shift_o is high in the cycle after acceptance.
  - On the final bit, shift_o and word_done_o are high in the same cycle, so the register contents are final one edge after word_done_o.
- abort_i:
  - In SHIFT, abort_i=1 forces state<=IDLE and bit_cnt_o<=0.
  - A simultaneous serial bit is not accepted (ser_ready_o=0) and produces no strobe.
  - abort_i is ignored in IDLE and DONE.
- Ignored inputs: par_valid_i is ignored outside IDLE, and ser_valid_i is ignored outside SHIFT. No data is consumed in either case.
- Width rule: bit_cnt_o saturates at N_SHIFT and does not wrap within a frame.

Test Plan:
- Reset, then a frame: rst_i=0 for 2 cycles with par_valid_i=1 and ser_valid_i=1 -> all outputs 0, par_ready_o=0 during reset; after release, par_ready_o=1.
- Full frame (WIDTH=4, N_SHIFT=4): par_i=4'b1010 accepted, then ser bits 1,0,1,1 back-to-back -> ld_o pulses once with I_o4=1010; shift_o is high for 4 consecutive cycles with bstream_o=1,0,1,1; word_done_o coincides with the 4th shift_o; a model register ends at 4'b1011.
- Gapped serial input: ser_valid_i pattern 1,0,0,1,1,0,1 -> shift_o is high only in the 4 cycles after each accept; bit_cnt_o steps 1,1,1,2,3,3,4; word_done_o appears once.
- Abort: after 2 of 4 bits, abort_i=1 together with ser_valid_i=1 -> ser_ready_o=0, no shift_o, return to IDLE with bit_cnt_o=0; the next seed starts a clean frame.
- Ignored inputs: par_valid_i held high through SHIFT and DONE -> no second ld_o until IDLE, then exactly one ld_o per accept; ser_valid_i in IDLE -> no shift_o.
- Reset mid-frame: rst_i=0 at bit 3 -> the next cycle has shift_o=0, ld_o=0, state IDLE; no word_done_o is ever emitted for that frame.
